sample_uart_framer: RTL and testbench
=====================================

// Module: sample_uart_framer
// PURPOSE
//  Downstream of the codec sample path: snapshots all four channels on a decimated sample_clk edge.
//  Serialises each snapshot into a fixed 12-byte telemetry frame.
//  Drives an existing uart_tx (tx_start/tx_data/tx_busy handshake).
//  Replaces ad-hoc per-byte framing logic at top level.
//  All four channels in one frame come from the same sample instant.
// PARAMETERS
//  DECIMATE  480   sample_clk rising edges per frame (>=1); 480 -> 100 frames/s at 48 kHz
//  HDR0      8'h43 first header byte ("C")
//  HDR1      8'h48 second header byte ("H")
// PORTS
//  clk          in   1   system clock; sample_clk and tx_busy are synchronous to it
//  rst_n        in   1   asynchronous active-low reset
//  en           in   1   1 = framing enabled
//  sample_clk   in   1   sample strobe from codec block, level signal
//  sample_in0   in   16  channel 0 sample, signed two's complement
//  sample_in1   in   16  channel 1 sample
//  sample_in2   in   16  channel 2 sample
//  sample_in3   in   16  channel 3 sample
//  tx_start     out  1   one-cycle pulse: uart_tx accepts tx_data
//  tx_data      out  8   byte to transmit; stable from start pulse until next start
//  tx_busy      in   1   uart_tx busy
//  frame_active out  1   frame in progress (snapshot cycle through last byte done)
//  overrun_cnt  out  8   dropped snapshots, saturating
// BEHAVIOUR
//  Reset values: all outputs 0; seq, decim counter, byte_idx 0; FSM in IDLE.
//  Edge detect: rise = sample_clk & ~sample_clk_q; sample_clk_q resets to 0.
//  Decimator:
//   - While en=1, counts rises; a rise with count==DECIMATE-1 is a "due" event, count -> 0.
//   - While en=0, count is held at 0.
//  Due while IDLE:
//   - Same clk: sample_in0..3 latched into shadow regs; frame_active <= 1; FSM -> LOAD.
//  Due while frame_active:
//   - Snapshot dropped; overrun_cnt += 1, saturating at 255.
//   - Frame in flight is unaffected.
//  Frame bytes, idx 0..11:
//   - HDR0, HDR1, seq.
//   - s0[15:8], s0[7:0], s1[15:8], s1[7:0], s2[15:8], s2[7:0], s3[15:8], s3[7:0].
//   - chk = XOR of bytes 2..10.
//  FSM:
//   - IDLE: wait for due.
//   - LOAD: tx_data <= byte[idx]; tx_start <= 1 for exactly 1 cycle; -> HOLD.
//   - HOLD: one cycle, tx_busy ignored; covers uart busy-rise latency; -> WAIT.
//   - WAIT: when tx_busy==0: if idx==11 -> IDLE, idx <= 0, seq += 1 (wraps 255->0), frame_active <= 0;
//     else idx += 1, -> LOAD.
//  Latency: first tx_start is 1 cycle after the snapshot cycle.
//  Exactly one tx_start pulse per byte.
//  en=0 mid-frame: current frame completes; no new due events.
//  Due and frame completion in the same cycle: counts as overrun (still active that cycle).
//  Reset mid-frame: immediate abort; tx_start=0; seq restarts at 0. No partial-frame recovery.
//  tx_busy stuck high: FSM waits indefinitely in WAIT; overruns accumulate.
// STRUCTURE
//  Package sample_uart_framer_pkg:
//   - FSM state enum {IDLE, LOAD, HOLD, WAIT}.
//   - FRAME_LEN=12, HDR defaults, CHK_IDX=11.
//  Sub-module sample_edge_decim:
//   - Ports: clk, rst_n, en, sample_clk -> due.
//   - Contains edge register and DECIMATE counter.
//  Top of this file: shadow regs, byte mux, seq/overrun counters, FSM.
// TESTING
//  1. DECIMATE=4; samples 1234/5678/9ABC/DEF0; uart model busy 10 cyc -> 43 48 00 12 34 56 78 9A BC DE F0 00.
//     Next frame: seq 01, chk 01.
//  2. Change sample_in every clk during frame -> all bytes equal values latched at snapshot cycle.
//  3. tx_busy held high 2000 cyc, DECIMATE=1 -> overrun_cnt increments per rise, saturates at FF.
//     Frame resumes intact afterwards.
//  4. en=0 from reset -> no tx_start.
//     en dropped after byte 3 -> bytes 4..11 still sent, then silence.
//  5. rst_n low after byte 5 -> tx_start/frame_active 0 immediately.
//     After release, next frame has seq 00 and correct chk.
//  6. uart model raises tx_busy 1 cycle after start -> exactly 12 start pulses per frame, no duplicates.

Source files
------------

// File: rtl/sample_uart_framer_pkg.sv
// ----------------------------------------------------------------------------
// sample_uart_framer_pkg
//   Shared types, frame layout constants and byte-mux helpers for the
//   four-channel telemetry framer.
//   Contents:
//     state_e      framer FSM states
//     snap_t       four 16-bit channel samples taken at one instant
//     payload_byte bytes 2..10 of a frame (seq + big-endian samples)
//     frame_byte   any byte 0..11 of a frame, including the XOR checksum
// ----------------------------------------------------------------------------
package sample_uart_framer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2,
      ST_WAIT = 2'd3
   } state_e;

   localparam int unsigned FRAME_LEN = 12;
   localparam int unsigned CHK_IDX   = 11;
   localparam logic [3:0]  IDX_LAST  = 4'(CHK_IDX);
   localparam logic [7:0]  HDR0_DEF  = 8'h43;  // "C"
   localparam logic [7:0]  HDR1_DEF  = 8'h48;  // "H"

   typedef logic [15:0] sample_t;

   typedef struct packed {
      sample_t s3;
      sample_t s2;
      sample_t s1;
      sample_t s0;
   } snap_t;

   // Sequence byte followed by each channel, high byte first.
   function automatic logic [7:0] payload_byte(input logic [3:0] idx,
                                               input logic [7:0] seq,
                                               input snap_t      s);
      logic [7:0] b;
      case (idx)
         4'd2:    b = seq;
         4'd3:    b = s.s0[15:8];
         4'd4:    b = s.s0[7:0];
         4'd5:    b = s.s1[15:8];
         4'd6:    b = s.s1[7:0];
         4'd7:    b = s.s2[15:8];
         4'd8:    b = s.s2[7:0];
         4'd9:    b = s.s3[15:8];
         4'd10:   b = s.s3[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Headers are excluded from the checksum; it covers seq and samples only.
   function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                             input logic [7:0] hdr0,
                                             input logic [7:0] hdr1,
                                             input logic [7:0] seq,
                                             input snap_t      s);
      logic [7:0] chk;
      logic [7:0] b;
      chk = 8'h00;
      for (int i = 2; i <= 10; i++) begin
         chk = chk ^ payload_byte(4'(i), seq, s);
      end
      case (idx)
         4'd0:    b = hdr0;
         4'd1:    b = hdr1;
         IDX_LAST: b = chk;
         default: b = payload_byte(idx, seq, s);
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sample_uart_framer_edge_decim.sv
// ----------------------------------------------------------------------------
// sample_edge_decim
//   Detects rising edges of the level-type sample_clk and emits a one-cycle
//   'due' strobe on every DECIMATE-th rise while enabled.
//   Ports:
//     clk        in  system clock
//     rst_n      in  asynchronous active-low reset
//     en         in  1 = count rises; 0 = counter held at zero
//     sample_clk in  sample strobe, synchronous to clk
//     due        out combinational strobe, high in the cycle of the due rise
// ----------------------------------------------------------------------------
module sample_edge_decim #(
   parameter int unsigned DECIMATE = 480
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic sample_clk,
   output logic due
);

   // A one-bit counter keeps DECIMATE=1 legal; it simply never leaves zero.
   localparam int unsigned CW   = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
   localparam logic [CW-1:0] LAST = CW'(DECIMATE - 1);

   logic          sample_clk_q, sample_clk_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      sample_clk_d = sample_clk;
      cnt_d        = cnt_q;
      due          = 1'b0;
      rise         = sample_clk & ~sample_clk_q;
      if (!en) begin
         cnt_d = '0;
      end else if (rise) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
            due   = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_clk_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sample_clk_q <= sample_clk_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: rtl/sample_uart_framer.sv
// ----------------------------------------------------------------------------
// sample_uart_framer
//   Snapshots four codec channels on a decimated sample_clk rise and sends
//   each snapshot as a 12-byte frame through a uart_tx start/busy handshake:
//     HDR0 HDR1 seq s0h s0l s1h s1l s2h s2l s3h s3l chk
//   Ports:
//     clk, rst_n           system clock, asynchronous active-low reset
//     en                   1 = new snapshots allowed
//     sample_clk           level sample strobe from the codec block
//     sample_in0..3        channel samples (signed 16-bit)
//     tx_start/tx_data     one-cycle start pulse and the byte it carries
//     tx_busy              uart_tx busy
//     frame_active         snapshot cycle through completion of last byte
//     overrun_cnt          snapshots dropped while a frame was in flight
// ----------------------------------------------------------------------------
module sample_uart_framer
   import sample_uart_framer_pkg::*;
#(
   parameter int unsigned DECIMATE = 480,
   parameter logic [7:0]  HDR0     = HDR0_DEF,
   parameter logic [7:0]  HDR1     = HDR1_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        sample_clk,
   input  logic [15:0] sample_in0,
   input  logic [15:0] sample_in1,
   input  logic [15:0] sample_in2,
   input  logic [15:0] sample_in3,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   output logic        frame_active,
   output logic [7:0]  overrun_cnt
);

   logic due;

   sample_edge_decim #(.DECIMATE(DECIMATE)) u_edge_decim (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .sample_clk (sample_clk),
      .due        (due)
   );

   state_e     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] seq_q, seq_d;
   snap_t      snap_q, snap_d;
   logic       frame_active_q, frame_active_d;
   logic [7:0] ovr_q, ovr_d;
   logic       tx_start_q, tx_start_d;
   logic [7:0] tx_data_q, tx_data_d;

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      seq_d          = seq_q;
      snap_d         = snap_q;
      frame_active_d = frame_active_q;
      ovr_d          = ovr_q;
      tx_start_d     = 1'b0;
      tx_data_d      = tx_data_q;

      // frame_active_q is still high in the completion cycle, so a due that
      // coincides with completion is dropped rather than started.
      if (due && frame_active_q && (ovr_q != 8'hFF)) begin
         ovr_d = ovr_q + 8'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (due) begin
               snap_d         = '{s3: sample_in3, s2: sample_in2,
                                  s1: sample_in1, s0: sample_in0};
               frame_active_d = 1'b1;
               state_d        = ST_LOAD;
            end
         end
         ST_LOAD: state_d = ST_HOLD;
         // uart_tx raises busy one cycle after start; skip that cycle so a
         // stale low busy is not mistaken for completion.
         ST_HOLD: state_d = ST_WAIT;
         ST_WAIT: begin
            if (!tx_busy) begin
               if (idx_q == IDX_LAST) begin
                  idx_d          = 4'd0;
                  seq_d          = seq_q + 8'd1;
                  frame_active_d = 1'b0;
                  state_d        = ST_IDLE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = ST_LOAD;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Start and data are registered on entry to LOAD so the pulse is
      // visible during the LOAD cycle itself, one cycle after the snapshot.
      // Next-state snapshot/index are used so the first byte sees the
      // shadow values being captured in this same cycle.
      if (state_d == ST_LOAD) begin
         tx_start_d = 1'b1;
         tx_data_d  = frame_byte(idx_d, HDR0, HDR1, seq_q, snap_d);
      end
   end

   // NOTE: the shadow registers are reset along with the control state so
   // a frame can never carry values left over from before reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         idx_q          <= 4'd0;
         seq_q          <= 8'd0;
         snap_q         <= '0;
         frame_active_q <= 1'b0;
         ovr_q          <= 8'd0;
         tx_start_q     <= 1'b0;
         tx_data_q      <= 8'd0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         seq_q          <= seq_d;
         snap_q         <= snap_d;
         frame_active_q <= frame_active_d;
         ovr_q          <= ovr_d;
         tx_start_q     <= tx_start_d;
         tx_data_q      <= tx_data_d;
      end
   end

   assign tx_start     = tx_start_q;
   assign tx_data      = tx_data_q;
   assign frame_active = frame_active_q;
   assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_sample_uart_framer.sv
// ----------------------------------------------------------------------------
// tb_sample_uart_framer
//   Directed sequence with randomized sample data against a frame-level
//   reference model; a simple uart_tx model supplies tx_busy.
// ----------------------------------------------------------------------------
module tb_sample_uart_framer;

   localparam int DEC = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        sample_clk;
   logic [15:0] s0, s1, s2, s3;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        frame_active;
   logic [7:0]  overrun_cnt;

   always #5 clk = ~clk;

   sample_uart_framer #(.DECIMATE(DEC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .sample_clk   (sample_clk),
      .sample_in0   (s0),
      .sample_in1   (s1),
      .sample_in2   (s2),
      .sample_in3   (s3),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_busy      (tx_busy),
      .frame_active (frame_active),
      .overrun_cnt  (overrun_cnt)
   );

   // ---------------- uart_tx model ----------------
   int         busy_len  = 10;
   bit         stuck     = 1'b0;
   int         busy_cnt  = 0;
   logic       prev_start = 1'b0;
   int         start_cnt = 0;
   int         dup_cnt   = 0;
   logic [7:0] cap_q[$];

   always @(posedge clk) begin
      prev_start <= tx_start;
      if (tx_start) begin
         cap_q.push_back(tx_data);
         start_cnt <= start_cnt + 1;
         busy_cnt  <= busy_len;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
      end
      if (tx_start && prev_start) dup_cnt <= dup_cnt + 1;
   end

   assign tx_busy = stuck | (busy_cnt > 0);

   // ---------------- reference model ----------------
   int         rcnt     = 0;
   bit         m_en     = 1'b0;
   bit         m_active = 1'b0;
   logic [7:0] m_seq    = 8'd0;
   logic [7:0] m_ovr    = 8'd0;
   logic [7:0] exp_q[$];
   logic [7:0] last_frame [12];
   bit         scramble = 1'b0;
   int         checks   = 0;
   int         errors   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic randomize_samples();
      s0 = 16'($urandom);
      s1 = 16'($urandom);
      s2 = 16'($urandom);
      s3 = 16'($urandom);
   endtask

   // A due event either starts a frame from the current samples or is
   // counted as an overrun.
   task automatic model_due();
      logic [7:0] b [12];
      if (m_active) begin
         if (m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
      end else begin
         b[0]  = 8'h43;      b[1]  = 8'h48;      b[2]  = m_seq;
         b[3]  = s0[15:8];   b[4]  = s0[7:0];
         b[5]  = s1[15:8];   b[6]  = s1[7:0];
         b[7]  = s2[15:8];   b[8]  = s2[7:0];
         b[9]  = s3[15:8];   b[10] = s3[7:0];
         b[11] = 8'h00;
         for (int i = 2; i <= 10; i++) b[11] = b[11] ^ b[i];
         for (int i = 0; i < 12; i++) exp_q.push_back(b[i]);
         m_active = 1'b1;
         m_seq    = m_seq + 8'd1;
      end
   endtask

   task automatic set_en(input bit v);
      en   = v;
      m_en = v;
      if (!v) rcnt = 0;
   endtask

   // One sample_clk rise: high for one clk, low for one clk.
   task automatic rise();
      @(negedge clk);
      if (scramble) randomize_samples();
      sample_clk = 1'b1;
      if (m_en) begin
         if (rcnt == DEC - 1) begin
            rcnt = 0;
            model_due();
         end else begin
            rcnt++;
         end
      end else begin
         rcnt = 0;
      end
      @(negedge clk);
      sample_clk = 1'b0;
      if (scramble) randomize_samples();
   endtask

   task automatic wait_bytes(input string tag, input int n);
      int t = 0;
      while (cap_q.size() < n && t < 5000) begin
         @(negedge clk);
         if (scramble) randomize_samples();
         t++;
      end
      check({tag, "_bytes_seen"}, 32'(cap_q.size() >= n), 32'd1);
   endtask

   task automatic check_frame(input string tag);
      logic [7:0] o, e;
      for (int i = 0; i < 12; i++) begin
         o = (cap_q.size() > 0) ? cap_q.pop_front() : 8'hxx;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         last_frame[i] = o;
         check($sformatf("%s_b%0d", tag, i), 32'(o), 32'(e));
      end
   endtask

   task automatic finish_frame(input string tag);
      wait_bytes(tag, 12);
      check_frame(tag);
      repeat (busy_len + 6) begin
         @(negedge clk);
         if (scramble) randomize_samples();
      end
      m_active = 1'b0;
      check({tag, "_idle_after"}, 32'(frame_active), 32'd0);
   endtask

   initial begin
      int sc;
      rst_n = 1'b0; en = 1'b0; sample_clk = 1'b0;
      s0 = '0; s1 = '0; s2 = '0; s3 = '0;
      repeat (3) @(negedge clk);
      check("rst_tx_start",     32'(tx_start),     32'd0);
      check("rst_tx_data",      32'(tx_data),      32'd0);
      check("rst_frame_active", 32'(frame_active), 32'd0);
      check("rst_overrun",      32'(overrun_cnt),  32'd0);
      rst_n = 1'b1;

      // Disabled from reset: rises must not start anything.
      repeat (8) rise();
      check("en0_no_start", 32'(start_cnt), 32'd0);
      check("en0_inactive", 32'(frame_active), 32'd0);

      // Fixed-pattern frame and first-byte latency.
      s0 = 16'h1234; s1 = 16'h5678; s2 = 16'h9ABC; s3 = 16'hDEF0;
      set_en(1'b1);
      repeat (3) begin
         rise();
         check("pre_due_idle", 32'(frame_active), 32'd0);
      end
      rise();
      check("lat_start",  32'(tx_start),     32'd1);
      check("lat_active", 32'(frame_active), 32'd1);
      check("lat_byte0",  32'(tx_data),      32'h43);
      finish_frame("f1");
      check("f1_seq", 32'(last_frame[2]),  32'h00);
      check("f1_s0h", 32'(last_frame[3]),  32'h12);
      check("f1_chk", 32'(last_frame[11]), 32'h00);
      repeat (4) rise();
      finish_frame("f2");
      check("f2_seq", 32'(last_frame[2]),  32'h01);
      check("f2_chk", 32'(last_frame[11]), 32'h01);

      // Fast uart: busy for one cycle only.
      busy_len = 1;
      sc = start_cnt;
      randomize_samples();
      repeat (4) rise();
      finish_frame("f3");
      check("f3_start_pulses", 32'(start_cnt - sc), 32'd12);
      check("f3_no_dup_start", 32'(dup_cnt), 32'd0);
      busy_len = 10;

      // Samples change every clock: frame must hold the snapshot values.
      scramble = 1'b1;
      repeat (4) rise();
      finish_frame("f4_scramble");

      // uart stuck busy: overruns accumulate and saturate.
      stuck = 1'b1;
      repeat (4) rise();
      repeat (40) rise();
      check("ovr_mid",        32'(overrun_cnt), 32'(m_ovr));
      check("stuck_one_byte", 32'(cap_q.size()), 32'd1);
      check("stuck_active",   32'(frame_active), 32'd1);
      repeat (1060) rise();
      check("ovr_sat_model", 32'(overrun_cnt), 32'(m_ovr));
      check("ovr_sat_ff",    32'(overrun_cnt), 32'hFF);
      stuck = 1'b0;
      finish_frame("f5_after_stuck");
      scramble = 1'b0;

      // en dropped after byte 3: frame completes, then silence.
      randomize_samples();
      repeat (4) rise();
      wait_bytes("f6_first4", 4);
      @(negedge clk);
      set_en(1'b0);
      repeat (8) rise();
      finish_frame("f6_en_drop");
      sc = start_cnt;
      repeat (8) rise();
      repeat (50) @(negedge clk);
      check("en_drop_silent", 32'(start_cnt - sc), 32'd0);

      // Reset mid-frame after byte 5.
      set_en(1'b1);
      randomize_samples();
      repeat (4) rise();
      wait_bytes("f7_first6", 6);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_tx_start", 32'(tx_start),     32'd0);
      check("midrst_active",   32'(frame_active), 32'd0);
      check("midrst_overrun",  32'(overrun_cnt),  32'd0);
      m_seq = 8'd0; m_ovr = 8'd0; m_active = 1'b0; rcnt = 0;
      exp_q.delete();
      cap_q.delete();
      repeat (12) @(negedge clk);
      rst_n = 1'b1;
      randomize_samples();
      repeat (4) rise();
      finish_frame("f8_post_rst");
      check("f8_seq", 32'(last_frame[2]), 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
